// File: rtl/ack_cts_responder.sv
// Schedules an ACK (or, with RESP_CTS_EN defined, a CTS) reply to a received
// frame addressed to us; the request is raised SIFS after a good FCS.
module ack_cts_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsf_pulse_1M,
  input  logic        resp_enable,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic [7:0]  signal_rate,
  input  logic        FC_DI_valid,
  input  logic [1:0]  FC_type,
  input  logic [3:0]  FC_subtype,
  input  logic [15:0] duration,
  input  logic        addr1_valid,
  input  logic [47:0] addr1,
  input  logic        addr2_valid,
  input  logic [47:0] addr2,
  input  logic [47:0] self_mac_addr,
  input  logic        fcs_in_strobe,
  input  logic        fcs_valid,
  input  logic [6:0]  sifs_time,
  input  logic [6:0]  preamble_sig_time,
  input  logic [4:0]  ofdm_symbol_time,
  input  logic [2:0]  ackcts_n_sym,
  input  logic        resp_ack,
  output logic        resp_req,
  output logic        resp_is_cts,
  output logic [47:0] resp_ra,
  output logic [15:0] resp_duration,
  output logic [3:0]  resp_rate,
  output logic        resp_drop
);

`ifdef RESP_CTS_EN
  localparam bit CtsEn = 1'b1;
`else
  localparam bit CtsEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, WAIT_FC, WAIT_ADDR, WAIT_FCS, SIFS_WAIT, REQ
  } state_t;

  state_t      state_q;
  logic [15:0] dur_q;
  logic        captured_q;
  logic [6:0]  sifs_cnt_q;
  logic [3:0]  tick_cnt_q;

  logic [11:0] resp_time;
  logic [12:0] overhead;
  logic [15:0] resp_duration_d;
  logic        in_frame;
  logic        fc_ack;
  logic        fc_rts;
  logic        fc_accept;
  logic        unused_rate_hi;

  assign unused_rate_hi = ^signal_rate[7:4];

  assign resp_time = 12'(preamble_sig_time) + 12'(ofdm_symbol_time) * 12'(ackcts_n_sym);
  assign overhead  = 13'(sifs_time) + 13'(resp_time);

  // Remaining NAV after our reply; a set bit 15 means the field is not a duration.
  always_comb begin
    resp_duration_d = '0;
    if (!dur_q[15] && ({1'b0, dur_q[14:0]} >= {3'b000, overhead}))
      resp_duration_d = {1'b0, dur_q[14:0]} - {3'b000, overhead};
  end

  assign in_frame  = (state_q == WAIT_FC) || (state_q == WAIT_ADDR) || (state_q == WAIT_FCS);
  assign fc_ack    = (FC_type == 2'b00) || (FC_type == 2'b10);
  assign fc_rts    = (FC_type == 2'b01) && (FC_subtype == 4'b1011);
  assign fc_accept = fc_ack || (fc_rts && CtsEn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      resp_req      <= 1'b0;
      resp_is_cts   <= 1'b0;
      resp_ra       <= '0;
      resp_duration <= '0;
      resp_rate     <= '0;
      resp_drop     <= 1'b0;
      dur_q         <= '0;
      captured_q    <= 1'b0;
      sifs_cnt_q    <= '0;
      tick_cnt_q    <= '0;
    end else begin
      resp_drop <= 1'b0;
      if (!resp_enable && state_q != REQ) begin
        state_q <= IDLE;
      end else if (in_frame && pkt_header_valid_strobe) begin
        captured_q <= 1'b0;
        if (pkt_header_valid) begin
          state_q   <= WAIT_FC;
          resp_rate <= signal_rate[3:0];
        end else begin
          state_q <= IDLE;
        end
      end else begin
        if ((state_q == WAIT_ADDR || state_q == WAIT_FCS) && addr2_valid) begin
          resp_ra    <= addr2;
          captured_q <= 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (pkt_header_valid_strobe && pkt_header_valid) begin
              state_q    <= WAIT_FC;
              resp_rate  <= signal_rate[3:0];
              captured_q <= 1'b0;
            end
          end
          WAIT_FC: begin
            if (FC_DI_valid) begin
              if (fc_accept) begin
                state_q     <= WAIT_ADDR;
                resp_is_cts <= fc_rts && CtsEn;
                dur_q       <= duration;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          WAIT_ADDR: begin
            if (addr1_valid)
              state_q <= (addr1 == self_mac_addr && !addr1[0]) ? WAIT_FCS : IDLE;
          end
          WAIT_FCS: begin
            if (fcs_in_strobe) begin
              if (fcs_valid && captured_q) begin
                state_q       <= SIFS_WAIT;
                sifs_cnt_q    <= sifs_time;
                resp_duration <= resp_duration_d;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          SIFS_WAIT: begin
            if (sifs_cnt_q == 7'd0) begin
              state_q    <= REQ;
              resp_req   <= 1'b1;
              tick_cnt_q <= '0;
            end else if (tsf_pulse_1M) begin
              sifs_cnt_q <= sifs_cnt_q - 7'd1;
            end
          end
          REQ: begin
            if (resp_ack) begin
              state_q  <= IDLE;
              resp_req <= 1'b0;
            end else if (tsf_pulse_1M) begin
              if (tick_cnt_q == 4'd15) begin
                state_q   <= IDLE;
                resp_req  <= 1'b0;
                resp_drop <= 1'b1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ack_cts_responder.md
ACK_CTS_RESPONDER -- requirements
Module: ack_cts_responder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have: tsf_pulse_1M  in  1  1 us tick; resp_enable  in  1  responder on/off.
REQ-003 SHALL have: pkt_header_valid_strobe  in  1; pkt_header_valid  in  1; signal_rate  in  8  received rate, [7] ht flag.
REQ-004 SHALL have: FC_DI_valid  in  1; FC_type  in  2; FC_subtype  in  4; duration  in  16  received duration field.
REQ-005 SHALL have: addr1_valid  in  1; addr1  in  48; addr2_valid  in  1; addr2  in  48; self_mac_addr  in  48.
REQ-006 SHALL have: fcs_in_strobe  in  1; fcs_valid  in  1.
REQ-007 SHALL have: sifs_time  in  7; preamble_sig_time  in  7; ofdm_symbol_time  in  5; ackcts_n_sym  in  3  (all in us/symbols).
REQ-008 SHALL have: resp_ack  in  1  tx core accepted request.
REQ-009 SHALL have outputs: resp_req  1; resp_is_cts  1; resp_ra  48; resp_duration  16; resp_rate  4; resp_drop  1  one-cycle pulse.

Function
REQ-010 States: IDLE, WAIT_FC, WAIT_ADDR, WAIT_FCS, SIFS_WAIT, REQ.
REQ-011 IDLE -> WAIT_FC on pkt_header_valid_strobe with pkt_header_valid=1 and resp_enable=1; latch resp_rate=signal_rate[3:0].
REQ-012 In WAIT_FC, WAIT_ADDR, WAIT_FCS, a new pkt_header_valid_strobe restarts the frame: -> WAIT_FC if pkt_header_valid and resp_enable, else -> IDLE.
REQ-013 WAIT_FC on FC_DI_valid: type 00 or 10 -> ACK, type 01 subtype 1011 -> CTS, both -> WAIT_ADDR, latch duration; all else -> IDLE.
REQ-014 WAIT_ADDR on addr1_valid: addr1==self_mac_addr and addr1[0]==0 -> WAIT_FCS; otherwise -> IDLE.
REQ-015 addr2 latched into resp_ra on addr2_valid in WAIT_ADDR or WAIT_FCS; a captured-flag is set.
REQ-016 WAIT_FCS on fcs_in_strobe: fcs_valid=1 and captured-flag=1 -> SIFS_WAIT with counter=sifs_time; else -> IDLE.
REQ-017 resp_time = preamble_sig_time + ofdm_symbol_time*ackcts_n_sym, 12-bit unsigned.
REQ-018 resp_duration[14:0] = latched duration[14:0] - sifs_time - resp_time, saturated to 0; resp_duration[15]=0; if latched duration[15]=1 then resp_duration=0.
REQ-019 SIFS_WAIT: counter decrements on tsf_pulse_1M, holds at 0; counter==0 -> REQ next cycle; sifs_time=0 gives REQ one cycle after FCS.
REQ-020 SIFS_WAIT and REQ ignore pkt_header_valid_strobe and fcs_in_strobe.
REQ-021 resp_req=1 exactly while in REQ; resp_ra, resp_duration, resp_is_cts, resp_rate stable while resp_req=1.
REQ-022 REQ: resp_ack=1 -> IDLE, resp_req low next cycle; resp_ack outside REQ ignored.
REQ-023 REQ timeout: 16 tsf_pulse_1M ticks without resp_ack -> IDLE with resp_drop pulse 1 cycle.
REQ-024 resp_enable deasserted in any state other than REQ -> IDLE next cycle; no resp_drop.

Reset
REQ-025 On rst: state IDLE, resp_req=0, resp_is_cts=0, resp_ra=0, resp_duration=0, resp_rate=0, resp_drop=0, counters and captured-flag 0.
REQ-026 rst in any state, including REQ, takes effect next edge with no resp_drop.

Configuration
REQ-027 Macro RESP_CTS_EN defined: RTS handled per REQ-013 with resp_is_cts=1.
REQ-028 RESP_CTS_EN undefined: RTS -> IDLE from WAIT_FC; resp_is_cts constant 0.

Verification
REQ-029 Data frame, addr1=self, addr2=A, duration=0, FCS ok, sifs=16 -> resp_req 16 ticks after FCS, resp_ra=A, resp_duration=0, resp_is_cts=0.
REQ-030 RTS (RESP_CTS_EN), duration=300, sifs=16, preamble=20, sym=4, n_sym=3 -> resp_is_cts=1, resp_duration=252.
REQ-031 Frame addr1=self, fcs_valid=0 -> no resp_req; addr1 group (bit0=1) -> no resp_req.
REQ-032 New header strobe during WAIT_FCS, second frame to other MAC -> no resp_req.
REQ-033 Hold resp_ack=0 in REQ -> resp_drop pulse after 16 ticks, state IDLE.
REQ-034 rst asserted in SIFS_WAIT -> all outputs 0 next cycle; later valid frame answered normally.
